// File: rtl/return_address_stack.sv
// Circular return-address stack for the 16-bit fetch path: calls push PC+2,
// returns pop it back; overflow overwrites the oldest entry, errors are sticky.
module return_address_stack #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    input  logic              clear_err,
    output logic [ADDR_W-1:0] top_addr,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              ret_valid,
    output logic              empty,
    output logic              full,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic              underflow,
    output logic              misalign
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic              ret_valid_q, ret_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              misalign_q, misalign_d;

    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] push_val;
    logic              pop_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_CNT);
    assign top_idx  = sp_q - 1'b1;
    assign push_val = {push_addr[ADDR_W-1:1], 1'b0};
    assign pop_ok   = pop && !empty;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        sp_d        = sp_q;
        count_d     = count_q;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = sp_q;
        overflow_d  = clear_err ? 1'b0 : overflow_q;
        underflow_d = clear_err ? 1'b0 : underflow_q;
        misalign_d  = clear_err ? 1'b0 : misalign_q;

        if (push && pop_ok) begin
            // Return then call: hand back the top and replace it in place.
            ret_addr_d  = mem_q[top_idx];
            ret_valid_d = 1'b1;
            wr_en       = 1'b1;
            wr_idx      = top_idx;
        end else if (pop_ok) begin
            ret_addr_d  = mem_q[top_idx];
            ret_valid_d = 1'b1;
            sp_d        = sp_q - 1'b1;
            count_d     = count_q - 1'b1;
        end else if (push) begin
            wr_en = 1'b1;
            sp_d  = sp_q + 1'b1;
            if (full) overflow_d = 1'b1;
            else      count_d    = count_q + 1'b1;
        end

        if (pop && empty)            underflow_d = 1'b1;
        if (push && push_addr[0])    misalign_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            sp_q        <= '0;
            count_q     <= '0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            misalign_q  <= misalign_d;
        end
    end

    // NOTE: storage is not reset; entries are only visible through count, so contents are don't-care.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem_q[wr_idx] <= push_val;
    end

    assign top_addr  = empty ? '0 : mem_q[top_idx];
    assign ret_addr  = ret_addr_q;
    assign ret_valid = ret_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack: expected return addresses are queued
// by the stimulus and checked by a monitor whenever ret_valid is presented.
module tb_return_address_stack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic [15:0] push_addr;
    logic        pop;
    logic        clear_err;
    logic [15:0] top_addr;
    logic [15:0] ret_addr;
    logic        ret_valid;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    return_address_stack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .clear_err (clear_err),
        .top_addr  (top_addr),
        .ret_addr  (ret_addr),
        .ret_valid (ret_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge with the given inputs, then inputs return to idle.
    task automatic cycle(input logic ps, input logic [15:0] a, input logic pp, input logic ce);
        push      = ps;
        push_addr = a;
        pop       = pp;
        clear_err = ce;
        @(posedge clk);
        #1;
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] a);
        cycle(1'b1, a, 1'b0, 1'b0);
    endtask

    task automatic do_pop(input logic [15:0] expect_ret);
        exp_q.push_back(expect_ret);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic check_flags(input string name, input logic [2:0] exp);
        check(name, {29'h0, overflow, underflow, misalign}, {29'h0, exp});
    endtask

    // Monitor: every ret_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ret_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ret_valid", 32'(ret_valid), 32'h0);
            end else begin
                check("ret_addr", 32'(ret_addr), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        push      = 1'b1;
        push_addr = 16'h0040;
        pop       = 1'b0;
        clear_err = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_empty", 32'(empty), 32'h1);
        check("reset_count", 32'(count), 32'h0);
        check("reset_top", 32'(top_addr), 32'h0);
        check("reset_ret_valid", 32'(ret_valid), 32'h0);
        check_flags("reset_flags", 3'b000);
        push  = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 16'h0, 1'b0, 1'b0);

        // Nesting
        do_push(16'h0012);
        do_push(16'h0034);
        do_push(16'h0056);
        check("nest_count", 32'(count), 32'h3);
        check("nest_top", 32'(top_addr), 32'h0056);
        do_pop(16'h0056);
        check("nest_ret_valid", 32'(ret_valid), 32'h1);
        check("nest_top_after_pop", 32'(top_addr), 32'h0034);
        do_pop(16'h0034);
        do_pop(16'h0012);
        check("nest_empty", 32'(empty), 32'h1);
        check("nest_top_empty", 32'(top_addr), 32'h0);

        // Overflow wrap
        for (int i = 0; i < 9; i++) do_push(16'h0100 + 16'(2 * i));
        check("ovf_count", 32'(count), 32'h8);
        check("ovf_full", 32'(full), 32'h1);
        check_flags("ovf_flags", 3'b100);
        check("ovf_top", 32'(top_addr), 32'h0110);
        for (int i = 0; i < 8; i++) do_pop(16'h0110 - 16'(2 * i));
        check("ovf_empty", 32'(empty), 32'h1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        check_flags("udf_flags", 3'b110);
        check("udf_ret_valid", 32'(ret_valid), 32'h0);
        check("udf_ret_hold", 32'(ret_addr), 32'h0102);
        check("udf_count", 32'(count), 32'h0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check_flags("clear_all", 3'b000);

        // Simultaneous push and pop
        do_push(16'h0AA0);
        do_push(16'h0BB0);
        exp_q.push_back(16'h0BB0);
        cycle(1'b1, 16'h0CC0, 1'b1, 1'b0);
        check("pp_ret_valid", 32'(ret_valid), 32'h1);
        check("pp_count", 32'(count), 32'h2);
        check("pp_top", 32'(top_addr), 32'h0CC0);
        check_flags("pp_flags", 3'b000);
        do_pop(16'h0CC0);
        do_pop(16'h0AA0);
        cycle(1'b1, 16'h0DD0, 1'b1, 1'b0);
        check_flags("pp_empty_flags", 3'b010);
        check("pp_empty_count", 32'(count), 32'h1);
        check("pp_empty_top", 32'(top_addr), 32'h0DD0);
        check("pp_empty_ret_valid", 32'(ret_valid), 32'h0);
        do_pop(16'h0DD0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // Simultaneous push and pop while full: top replaced, no overflow
        for (int i = 0; i < 8; i++) do_push(16'h0300 + 16'(2 * i));
        exp_q.push_back(16'h030E);
        cycle(1'b1, 16'h0400, 1'b1, 1'b0);
        check("ppfull_count", 32'(count), 32'h8);
        check("ppfull_top", 32'(top_addr), 32'h0400);
        check_flags("ppfull_flags", 3'b000);
        do_pop(16'h0400);
        check("ppfull_next_top", 32'(top_addr), 32'h030C);
        for (int i = 6; i >= 0; i--) do_pop(16'h0300 + 16'(2 * i));

        // Misalign and clear
        do_push(16'h0203);
        check("mis_top", 32'(top_addr), 32'h0202);
        check_flags("mis_flags", 3'b001);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check_flags("mis_cleared", 3'b000);
        do_pop(16'h0202);
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        check_flags("clear_vs_set", 3'b010);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) do_push(16'h0500 + 16'(2 * i));
        check("pre_rst_count", 32'(count), 32'h5);
        rst_n = 1'b0;
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        check("mid_rst_count", 32'(count), 32'h0);
        check("mid_rst_ret_valid", 32'(ret_valid), 32'h0);
        check("mid_rst_ret_addr", 32'(ret_addr), 32'h0);
        check("mid_rst_top", 32'(top_addr), 32'h0);
        rst_n = 1'b1;
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
- Hardware return-address stack (RAS) for the 16-bit MIPS fetch path.
- On a call (jal/jalr) it stores the sequential return address, PC+2, produced by the instruction-address incrementer.
- On a return (jr $ra) it hands that address back to fetch, so the control flow reverses what the call did.
- Circular LIFO: on overflow the oldest entry is overwritten, with sticky error flags.

Parameters:
- ADDR_W, 16, width of instruction addresses.
- DEPTH, 8, number of entries; must be a power of 2, at least 2.
- PTR_W, 3, log2(DEPTH); top-of-stack pointer width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- push  input  1  call retired; store push_addr.
- push_addr  input  ADDR_W  return address (PC+2) to store.
- pop  input  1  return retired; remove the top entry.
- clear_err  input  1  clears the sticky error flags.
- top_addr  output  ADDR_W  combinational; current top entry, or 0 when empty.
- ret_addr  output  ADDR_W  registered; address removed by the last accepted pop.
- ret_valid  output  1  one-cycle pulse, the cycle after an accepted pop.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  PTR_W+1  number of valid entries.
- overflow  output  1  sticky; a push while full overwrote the oldest entry.
- underflow  output  1  sticky; pop attempted while empty.
- misalign  output  1  sticky; push with push_addr[0] == 1.

Behaviour:
- Reset (rst_n low at a clk edge), all registered outputs and state:
  - sp = 0, count = 0, ret_addr = 0, ret_valid = 0.
  - overflow = underflow = misalign = 0.
  - Storage contents are don't-care.
  - Reset has priority over push, pop and clear_err, including mid-sequence: everything is lost and the stack is empty on the next cycle.
- Storage and pointer:
  - mem[0..DEPTH-1]; sp points at the next write slot.
  - top index = sp-1, modulo DEPTH (wraps).
  - top_addr = empty ? 0 : mem[sp-1].
- Alignment: the stored value is {push_addr[ADDR_W-1:1], 1'b0}. Bit 0 is forced to 0 and misalign is set if push_addr[0] == 1.
- Push only, not full:
  - mem[sp] <= addr; sp <= sp+1; count <= count+1.
- Push only, full:
  - mem[sp] <= addr; sp <= sp+1 (overwrites the oldest entry); count stays DEPTH; overflow <= 1.
- Pop only, not empty:
  - ret_addr <= mem[sp-1]; ret_valid <= 1; sp <= sp-1; count <= count-1.
- Pop only, empty:
  - No state change except underflow <= 1; ret_valid <= 0; ret_addr holds.
- Push and pop in the same cycle, not empty (return immediately followed by a call):
  - ret_addr <= old mem[sp-1]; ret_valid <= 1.
  - mem[sp-1] <= addr (top replaced).
  - sp and count unchanged; no overflow even if full.
- Push and pop in the same cycle, empty:
  - The pop is an underflow (underflow <= 1, ret_valid <= 0).
  - The push proceeds normally: count becomes 1.
- Neither push nor pop: ret_valid <= 0; everything else holds.
- clear_err:
  - Clears all three sticky flags.
  - If a flag-setting event happens in the same cycle, the set wins.
- Latency:
  - ret_addr and ret_valid appear one cycle after pop.
  - top_addr reflects a push or pop one cycle after that edge, i.e. as soon as the state updates.
- count never exceeds DEPTH and never goes below 0. sp wraps modulo DEPTH.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles with push=1 and push_addr=16'h0040 -> empty=1, count=0, top_addr=0, ret_valid=0, all flags 0.
- Nesting:
  - Push 16'h0012, then 16'h0034, then 16'h0056 -> count=3, top_addr=16'h0056.
  - Then 3 pops -> ret_addr 16'h0056, 16'h0034, 16'h0012, each with ret_valid one cycle after its pop.
  - Afterwards empty=1.
- Overflow wrap (DEPTH=8):
  - Push 16'h0100, 16'h0102, ... through 16'h0110 (9 pushes) -> count=8, overflow=1.
  - 8 pops return 16'h0110 down to 16'h0102; 16'h0100 is lost.
  - A 9th pop sets underflow=1 with ret_valid=0.
- Simultaneous push and pop:
  - With the stack holding 16'h0AA0 and 16'h0BB0, assert push+pop with push_addr=16'h0CC0.
  - Next cycle: ret_addr=16'h0BB0, ret_valid=1, count=2, top_addr=16'h0CC0.
  - Repeat on an empty stack with push_addr=16'h0DD0 -> underflow=1, count=1, top_addr=16'h0DD0.
- Misalign and clear:
  - Push 16'h0203 -> top_addr=16'h0202, misalign=1.
  - clear_err alone -> misalign=0.
  - clear_err together with a pop on an empty stack -> underflow=1.
- Reset mid-operation: after 5 pushes, assert rst_n=0 together with pop=1 -> next cycle count=0, ret_valid=0, ret_addr=0.
